// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the fetch-PC redirect controller: redirect causes, FSM states
// and the request record passed between the selector and the controller.
package pc_redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    EXC    = 3'd1,
    ERET   = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4
  } redirect_cause_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } redirect_state_t;

  typedef struct packed {
    logic            valid;
    redirect_cause_t cause;
    logic [63:0]     target;
  } redirect_req_t;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/redirect_prio_sel.sv
// Fixed-priority redirect selector (EXC > ERET > BRANCH > JUMP); mask suppresses
// branch and jump requests from squashed shadow instructions.
module redirect_prio_sel
  import pc_redirect_ctrl_pkg::*;
(
  input  logic          exc_req,
  input  logic [63:0]   exc_target,
  input  logic          eret_req,
  input  logic [63:0]   eret_target,
  input  logic          br_req,
  input  logic [63:0]   br_target,
  input  logic          jmp_req,
  input  logic [63:0]   jmp_target,
  input  logic          mask,
  output redirect_req_t sel
);

  always_comb begin
    sel = '{valid: 1'b0, cause: NONE, target: 64'd0};
    if (exc_req) begin
      sel = '{valid: 1'b1, cause: EXC, target: exc_target};
    end else if (eret_req) begin
      sel = '{valid: 1'b1, cause: ERET, target: eret_target};
    end else if (br_req && !mask) begin
      sel = '{valid: 1'b1, cause: BRANCH, target: br_target};
    end else if (jmp_req && !mask) begin
      sel = '{valid: 1'b1, cause: JUMP, target: jmp_target};
    end else begin
      sel = '{valid: 1'b0, cause: NONE, target: 64'd0};
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: arbitrates control-flow redirects, parks one while fetch is
// stalled, and masks branch/jump requests during the post-redirect shadow.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h0000_0000_0040_0000,
  parameter logic [63:0] HANDLER_RESET = 64'h0000_0000_8000_0180,
  parameter int          SHADOW_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_ready,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [63:0]     epc,
  input  logic            br_req,
  input  logic [63:0]     br_target,
  input  logic            jmp_req,
  input  logic [63:0]     jmp_target,
  input  logic            cfg_we,
  input  logic [63:0]     cfg_handler_addr,
  output logic [63:0]     pc_out,
  output logic            pc_valid,
  output logic            flush,
  output redirect_cause_t redirect_cause,
  output logic [31:0]     redirect_count
);

  redirect_state_t state_q;
  redirect_req_t   pend_q;
  redirect_req_t   new_sel;
  redirect_req_t   merged;
  logic [63:0]     pc_q;
  logic [63:0]     handler_q;
  logic [7:0]      shadow_q;
  logic            pc_valid_q;
  redirect_cause_t cause_q;
  logic [31:0]     count_q;

  logic            pend_active;
  logic [4:1]      mrg_req;
  logic [63:0]     mrg_tgt [1:4];

  redirect_prio_sel u_new_sel (
    .exc_req    (exc_req),
    .exc_target (handler_q),
    .eret_req   (eret_req),
    .eret_target(epc),
    .br_req     (br_req),
    .br_target  (br_target),
    .jmp_req    (jmp_req),
    .jmp_target (jmp_target),
    .mask       (shadow_q != 8'd0),
    .sel        (new_sel)
  );

  // Pending and new winner share one slot per cause; on a tie the pending
  // entry keeps its slot, so only a strictly higher new winner replaces it.
  assign pend_active = (state_q == HOLD) && pend_q.valid;

  always_comb begin
    for (int k = 1; k <= 4; k++) begin
      mrg_req[k] = 1'b0;
      mrg_tgt[k] = 64'd0;
      if (pend_active && (pend_q.cause == redirect_cause_t'(3'(k)))) begin
        mrg_req[k] = 1'b1;
        mrg_tgt[k] = pend_q.target;
      end else if (new_sel.valid && (new_sel.cause == redirect_cause_t'(3'(k)))) begin
        mrg_req[k] = 1'b1;
        mrg_tgt[k] = new_sel.target;
      end else begin
        mrg_req[k] = 1'b0;
        mrg_tgt[k] = 64'd0;
      end
    end
  end

  redirect_prio_sel u_merge_sel (
    .exc_req    (mrg_req[1]),
    .exc_target (mrg_tgt[1]),
    .eret_req   (mrg_req[2]),
    .eret_target(mrg_tgt[2]),
    .br_req     (mrg_req[3]),
    .br_target  (mrg_tgt[3]),
    .jmp_req    (mrg_req[4]),
    .jmp_target (mrg_tgt[4]),
    .mask       (1'b0),
    .sel        (merged)
  );

  assign flush          = pc_valid_q && merged.valid && if_ready;
  assign pc_out         = pc_q;
  assign pc_valid       = pc_valid_q;
  assign redirect_cause = cause_q;
  assign redirect_count = count_q;

  // Nothing is accepted until the PC becomes valid on the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pend_q     <= '{valid: 1'b0, cause: NONE, target: 64'd0};
      pc_q       <= RESET_PC;
      handler_q  <= HANDLER_RESET;
      shadow_q   <= 8'd0;
      pc_valid_q <= 1'b0;
      cause_q    <= NONE;
      count_q    <= 32'd0;
    end else begin
      pc_valid_q <= 1'b1;
      if (cfg_we) begin
        handler_q <= cfg_handler_addr;
      end
      if (pc_valid_q) begin
        if (merged.valid && if_ready) begin
          pc_q     <= merged.target;
          cause_q  <= merged.cause;
          count_q  <= count_q + 32'd1;
          shadow_q <= 8'(SHADOW_CYCLES);
          pend_q   <= '{valid: 1'b0, cause: NONE, target: 64'd0};
          state_q  <= RUN;
        end else if (merged.valid) begin
          pend_q  <= merged;
          state_q <= HOLD;
        end else if (if_ready) begin
          pc_q <= pc_q + PC_STEP;
          if (shadow_q != 8'd0) begin
            shadow_q <= shadow_q - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  localparam logic [63:0] RESET_PC      = 64'h0000_0000_0040_0000;
  localparam logic [63:0] HANDLER_RESET = 64'h0000_0000_8000_0180;
  localparam int          SHADOW        = 2;

  logic clk = 1'b0;
  logic rst_n, if_ready, exc_req, eret_req, br_req, jmp_req, cfg_we;
  logic [63:0] epc, br_target, jmp_target, cfg_handler_addr;
  logic [63:0] pc_out;
  logic pc_valid, flush;
  redirect_cause_t redirect_cause;
  logic [31:0] redirect_count;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .RESET_PC(RESET_PC), .HANDLER_RESET(HANDLER_RESET), .SHADOW_CYCLES(SHADOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .cfg_we(cfg_we), .cfg_handler_addr(cfg_handler_addr),
    .pc_out(pc_out), .pc_valid(pc_valid), .flush(flush),
    .redirect_cause(redirect_cause), .redirect_count(redirect_count)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state (cause numbers: 0 none, 1 exc, 2 eret, 3 branch, 4 jump).
  logic [63:0] m_pc, m_handler, m_ptgt;
  bit          m_hold, m_valid;
  int          m_pcause, m_shadow, m_cause;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_handler = HANDLER_RESET; m_ptgt = 64'd0;
    m_hold = 1'b0; m_valid = 1'b0; m_pcause = 0; m_shadow = 0;
    m_cause = 0; m_count = 32'd0;
  endtask

  // Lowest-numbered asserted source wins; branch/jump only count outside the shadow.
  function automatic void candidate(output int c, output logic [63:0] t);
    logic        r  [1:4];
    logic [63:0] tg [1:4];
    r[1] = exc_req;                     tg[1] = m_handler;
    r[2] = eret_req;                    tg[2] = epc;
    r[3] = br_req  && (m_shadow == 0);  tg[3] = br_target;
    r[4] = jmp_req && (m_shadow == 0);  tg[4] = jmp_target;
    c = 0; t = 64'd0;
    for (int k = 4; k >= 1; k--) if (r[k]) begin c = k; t = tg[k]; end
    if (m_hold && (c == 0 || c >= m_pcause)) begin
      c = m_pcause; t = m_ptgt;
    end
  endfunction

  task automatic model_update();
    int c; logic [63:0] t;
    if (!rst_n) begin
      model_reset();
    end else begin
      candidate(c, t);
      if (m_valid) begin
        if (c != 0 && if_ready) begin
          m_pc = t; m_cause = c; m_count = m_count + 32'd1;
          m_shadow = SHADOW; m_hold = 1'b0;
        end else if (c != 0) begin
          m_hold = 1'b1; m_pcause = c; m_ptgt = t;
        end else if (if_ready) begin
          m_pc = m_pc + 64'd4;
          if (m_shadow > 0) m_shadow--;
        end
      end
      if (cfg_we) m_handler = cfg_handler_addr;
      m_valid = 1'b1;
    end
  endtask

  task automatic compare_all();
    int c; logic [63:0] t;
    candidate(c, t);
    chk("pc_out", pc_out, m_pc);
    chk("pc_valid", pc_valid, m_valid);
    chk("flush", flush, m_valid && if_ready && (c != 0));
    chk("redirect_cause", redirect_cause, m_cause);
    chk("redirect_count", redirect_count, m_count);
  endtask

  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_ready = 1'b0; exc_req = 1'b0; eret_req = 1'b0; br_req = 1'b0;
    jmp_req = 1'b0; cfg_we = 1'b0; epc = 64'd0; br_target = 64'd0;
    jmp_target = 64'd0; cfg_handler_addr = 64'd0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_valid", pc_valid, 1'b0);
    chk("rst_count", redirect_count, 32'd0);
    chk("rst_cause", redirect_cause, 3'd0);
    chk("rst_flush", flush, 1'b0);

    rst_n = 1'b1; if_ready = 1'b1;
    tick(); #1 chk("seq_valid", pc_valid, 1'b1); chk("seq_pc0", pc_out, 64'h400000);
    tick(); #1 chk("seq_pc1", pc_out, 64'h400004);
    tick(); #1 chk("seq_pc2", pc_out, 64'h400008);

    br_req = 1'b1; br_target = 64'h400100; jmp_req = 1'b1; jmp_target = 64'h400200;
    #1 chk("br_flush", flush, 1'b1);
    tick(); #1 chk("br_pc", pc_out, 64'h400100);
    chk("br_cause", redirect_cause, 3'd3); chk("br_count", redirect_count, 32'd1);
    br_req = 1'b0;
    #1 chk("shadow_flush0", flush, 1'b0);
    tick(); #1 chk("shadow_pc1", pc_out, 64'h400104);
    tick(); #1 chk("shadow_pc2", pc_out, 64'h400108);
    chk("jmp_flush", flush, 1'b1);
    tick(); #1 chk("jmp_pc", pc_out, 64'h400200);
    chk("jmp_cause", redirect_cause, 3'd4); chk("jmp_count", redirect_count, 32'd2);

    jmp_req = 1'b0; tick(); tick();
    if_ready = 1'b0; jmp_req = 1'b1; jmp_target = 64'h500000;
    tick();
    jmp_req = 1'b0; exc_req = 1'b1;
    #1 chk("hold_flush", flush, 1'b0);
    tick();
    exc_req = 1'b0; if_ready = 1'b1;
    #1 chk("hold_commit_flush", flush, 1'b1);
    tick(); #1 chk("hold_pc", pc_out, 64'h80000180);
    chk("hold_cause", redirect_cause, 3'd1); chk("hold_count", redirect_count, 32'd3);

    cfg_we = 1'b1; cfg_handler_addr = 64'h9000; exc_req = 1'b1;
    tick(); cfg_we = 1'b0;
    #1 chk("cfg_old_handler", pc_out, 64'h80000180);
    exc_req = 1'b0; tick();
    exc_req = 1'b1; tick();
    #1 chk("cfg_new_handler", pc_out, 64'h9000); chk("cfg_count", redirect_count, 32'd5);
    exc_req = 1'b0;

    if_ready = 1'b0; eret_req = 1'b1; epc = 64'h1234;
    tick();
    eret_req = 1'b0; rst_n = 1'b0; model_reset();
    #1 chk("midhold_rst_pc", pc_out, RESET_PC); chk("midhold_rst_count", redirect_count, 32'd0);
    tick();
    rst_n = 1'b1; if_ready = 1'b1;
    #1 chk("midhold_no_flush", flush, 1'b0);
    tick(); #1 chk("midhold_pc", pc_out, RESET_PC); chk("midhold_flush2", flush, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if_ready   = ($urandom_range(0, 3) != 0);
      exc_req    = ($urandom_range(0, 15) == 0);
      eret_req   = ($urandom_range(0, 11) == 0);
      br_req     = ($urandom_range(0, 5) == 0);
      jmp_req    = ($urandom_range(0, 5) == 0);
      cfg_we     = ($urandom_range(0, 19) == 0);
      epc        = {$urandom, $urandom};
      br_target  = {$urandom, $urandom};
      jmp_target = {$urandom, $urandom};
      cfg_handler_addr = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Owns the fetch PC register and sequences every control-flow redirect into it.
- Redirect sources: exception handler entry, ERET, EX-stage taken branch, and ID-stage J/JR.
- Arbitrates the sources by fixed priority and holds a pending redirect while fetch is stalled.
- Masks branch/jump requests from squashed shadow instructions and owns the runtime-configurable exception handler address.

Parameters:
- RESET_PC, 64'h0000_0000_0040_0000, PC value loaded at reset.
- HANDLER_RESET, 64'h0000_0000_8000_0180, exception handler address after reset.
- SHADOW_CYCLES, 2, number of fetch-accepted cycles after a redirect during which branch/jump requests are ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_ready  in  1  fetch accepts pc_out this cycle
- exc_req  in  1  exception taken
- eret_req  in  1  ERET in ID
- epc  in  64  ERET target
- br_req  in  1  EX branch resolved taken
- br_target  in  64  branch target
- jmp_req  in  1  ID J/JR
- jmp_target  in  64  jump target
- cfg_we  in  1  write handler address
- cfg_handler_addr  in  64  new handler address
- pc_out  out  64  current fetch PC (pc_q)
- pc_valid  out  1  pc_out is meaningful
- flush  out  1  squash IF/ID/EX younger instructions (combinational)
- redirect_cause  out  3  cause of the last accepted redirect (redirect_cause_t)
- redirect_count  out  32  accepted redirects, wraps modulo 2^32

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, handler_q=HANDLER_RESET, state=RUN, pending cleared, shadow_cnt=0, pc_valid=0, redirect_cause=NONE, redirect_count=0, flush=0. pc_valid=1 from the first clock edge after deassertion.
- Priority: EXC > ERET > BRANCH > JUMP.
  - Targets: EXC→handler_q, ERET→epc, BRANCH→br_target, JUMP→jmp_target.
  - br_req and jmp_req are masked while shadow_cnt!=0.
  - Targets are used unmodified; no alignment checks.
- RUN state:
  - Winner and if_ready: flush=1 same cycle. Next edge: pc_q←target, redirect_cause←winner, redirect_count+1, shadow_cnt←SHADOW_CYCLES.
  - Winner and !if_ready: flush=0. Capture {target,cause} into pending; state→HOLD; pc_q held.
  - No winner and if_ready: pc_q←pc_q+4, wrapping modulo 2^64.
  - No winner and !if_ready: pc_q held.
- HOLD state:
  - Each cycle, a new winner with strictly higher priority than pending overwrites pending, including its target. Equal or lower priority is dropped.
  - On if_ready: flush=1. Commit pending (or a same-cycle strictly-higher winner) exactly as in RUN; state→RUN.
  - pc_q is unchanged while in HOLD.
- shadow_cnt: decrements by 1 on each if_ready cycle with no accepted redirect; saturates at 0. EXC and ERET are never masked.
- cfg_we: handler_q←cfg_handler_addr at the next edge. An exception in the same cycle uses the old handler_q. A pending EXC keeps the target captured at capture time.
- Simultaneous requests: only the winner is recorded. Losers are not queued; sources re-assert if still valid.
- Reset mid-HOLD: pending discarded, PC returns to RESET_PC.
- Latency: a redirect accepted in cycle N appears on pc_out in cycle N+1.

Decomposition:
- structures package additions:
  - redirect_cause_t enum (3 bits): NONE=0, EXC=1, ERET=2, BRANCH=3, JUMP=4.
  - redirect_state_t enum: RUN, HOLD.
  - redirect_req_t struct {logic valid; redirect_cause_t cause; logic [63:0] target;}.
- Sub-module redirect_prio_sel: combinational fixed-priority select with shadow masking.
  - Inputs: four requests and the shadow mask.
  - Output: one redirect_req_t.
  - Reused for the pending-vs-new comparison.

Test Plan:
- Reset release, if_ready=1, no requests → pc_out 0x400000, 0x400004, 0x400008 on successive cycles; pc_valid 0 then 1.
- br_req=1, br_target=0x400100, jmp_req=1, jmp_target=0x400200, if_ready=1 → flush=1 that cycle; next pc_out=0x400100; redirect_cause=BRANCH; redirect_count=1.
- Immediately after that redirect, jmp_req=1 for 2 if_ready cycles → ignored; pc_out 0x400104, 0x400108. Third cycle: jmp taken, target 0x400200.
- if_ready=0, jmp_req to 0x500000 (HOLD); then exc_req while stalled; then if_ready=1 → single flush; pc_out=0x80000180; cause=EXC; count+1.
- cfg_we with 0x9000 and exc_req in the same cycle → target 0x80000180. Later exc_req → target 0x9000.
- rst_n low mid-HOLD with eret_req pending, epc=0x1234 → pc_out=RESET_PC; redirect_count=0; no flush after release.
